// File: rtl/sync_fifo_ctrl_if.sv
// ============================================================================
// Module   : sync_fifo_ctrl_if
// Brief    : Handshake/status bundle between sync_fifo_ctrl and its user.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface sync_fifo_ctrl_if #(
   parameter int BITS_DEPTH = 8,
   parameter int BITS_WIDTH = 32
);
   logic [BITS_WIDTH-1:0] din;
   logic                  wr_en;
   logic                  rd_en;
   logic                  err_clr;
   logic [BITS_WIDTH-1:0] dout;
   logic                  dout_valid;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [BITS_DEPTH:0]   count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output din, wr_en, rd_en, err_clr,
      input  dout, dout_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  din, wr_en, rd_en, err_clr,
      output dout, dout_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );
endinterface

`default_nettype wire

// File: rtl/sync_fifo_ctrl.sv
// ============================================================================
// Module   : sync_fifo_ctrl
// Brief    : Guarded synchronous FIFO with thresholds, sticky errors and a
//            registered output. Define FIFO_FWFT_EN for first-word-fall-through.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo_ctrl #(
   parameter int BITS_DEPTH = 8,
   parameter int BITS_WIDTH = 32,
   parameter int AF_THRESH  = 2**BITS_DEPTH-4,
   parameter int AE_THRESH  = 4
) (
   input  wire logic       i_clk,
   input  wire logic       i_rst,
   sync_fifo_ctrl_if.slave bus
);
   localparam int                  DEPTH    = 2**BITS_DEPTH;
   localparam logic [BITS_DEPTH:0] AF_LEVEL = (BITS_DEPTH+1)'(AF_THRESH);
   localparam logic [BITS_DEPTH:0] AE_LEVEL = (BITS_DEPTH+1)'(AE_THRESH);

   logic [BITS_WIDTH-1:0] mem [DEPTH];
   logic [BITS_DEPTH:0]   wr_ptr;
   logic [BITS_DEPTH:0]   rd_ptr;
   logic [BITS_DEPTH:0]   count;
   logic [BITS_WIDTH-1:0] dout;
   logic                  dout_valid;
   logic                  overflow;
   logic                  underflow;

   logic mem_empty;
   logic mem_full;
   logic empty_flag;
   logic wr_acc;
   logic rd_acc;
   logic mem_pop;

   assign mem_empty = (wr_ptr == rd_ptr);
   assign mem_full  = (wr_ptr[BITS_DEPTH] != rd_ptr[BITS_DEPTH]) &&
                      (wr_ptr[BITS_DEPTH-1:0] == rd_ptr[BITS_DEPTH-1:0]);

`ifdef FIFO_FWFT_EN
   // The output stage refills from memory whenever it is empty or being popped.
   assign empty_flag = !dout_valid;
   assign rd_acc     = bus.rd_en && dout_valid;
   assign mem_pop    = !mem_empty && (!dout_valid || rd_acc);
`else
   assign empty_flag = mem_empty;
   assign rd_acc     = bus.rd_en && !mem_empty;
   assign mem_pop    = rd_acc;
`endif

   assign wr_acc = bus.wr_en && !mem_full;

   always_ff @(posedge i_clk) begin
      if (wr_acc) begin
         mem[wr_ptr[BITS_DEPTH-1:0]] <= bus.din;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (mem_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            dout   <= mem[rd_ptr[BITS_DEPTH-1:0]];
         end
`ifdef FIFO_FWFT_EN
         if (mem_pop) begin
            dout_valid <= 1'b1;
         end else if (rd_acc) begin
            dout_valid <= 1'b0;
         end
`else
         dout_valid <= rd_acc;
`endif
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // A rejection in the same cycle as err_clr keeps the flag set.
         overflow  <= (overflow  && !bus.err_clr) || (bus.wr_en && mem_full);
         underflow <= (underflow && !bus.err_clr) || (bus.rd_en && empty_flag);
      end
   end

   assign bus.dout         = dout;
   assign bus.dout_valid   = dout_valid;
   assign bus.full         = mem_full;
   assign bus.empty        = empty_flag;
   assign bus.count        = count;
   assign bus.almost_full  = (count >= AF_LEVEL);
   assign bus.almost_empty = (count <= AE_LEVEL);
   assign bus.overflow     = overflow;
   assign bus.underflow    = underflow;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_ctrl.sv
// ============================================================================
// Module   : tb_sync_fifo_ctrl
// Brief    : Directed self-checking bench for sync_fifo_ctrl (depth 8).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sync_fifo_ctrl;
   localparam int BD = 3;
   localparam int W  = 16;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   sync_fifo_ctrl_if #(.BITS_DEPTH(BD), .BITS_WIDTH(W)) bus ();

   sync_fifo_ctrl #(
      .BITS_DEPTH(BD),
      .BITS_WIDTH(W),
      .AF_THRESH (6),
      .AE_THRESH (1)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.wr_en   = 1'b0;
      bus.rd_en   = 1'b0;
      bus.err_clr = 1'b0;
      bus.din     = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      do_reset();
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_empty", 32'(bus.empty), 1);
      chk("rst_full", 32'(bus.full), 0);
      chk("rst_dout_valid", 32'(bus.dout_valid), 0);
      chk("rst_dout", 32'(bus.dout), 0);
      chk("rst_almost_empty", 32'(bus.almost_empty), 1);
      chk("rst_errs", 32'({bus.overflow, bus.underflow}), 0);

`ifdef FIFO_FWFT_EN
      bus.wr_en = 1'b1;
      bus.din   = 16'h00A5;
      tick();
      idle();
      chk("fwft_not_yet_valid", 32'(bus.dout_valid), 0);
      chk("fwft_count_k", 32'(bus.count), 1);
      tick();
      chk("fwft_dout", 32'(bus.dout), 32'h00A5);
      chk("fwft_valid", 32'(bus.dout_valid), 1);
      chk("fwft_empty", 32'(bus.empty), 0);
      bus.rd_en = 1'b1;
      tick();
      idle();
      chk("fwft_pop_valid", 32'(bus.dout_valid), 0);
      chk("fwft_pop_empty", 32'(bus.empty), 1);
      chk("fwft_pop_count", 32'(bus.count), 0);
      bus.rd_en = 1'b1;
      tick();
      idle();
      chk("fwft_underflow", 32'(bus.underflow), 1);
      for (int i = 0; i < 10; i++) begin
         bus.wr_en = 1'b1;
         bus.din   = 16'(16'h0100 + i);
         tick();
      end
      idle();
      chk("fwft_cap_count", 32'(bus.count), 9);
      chk("fwft_cap_full", 32'(bus.full), 1);
      chk("fwft_cap_overflow", 32'(bus.overflow), 1);
      for (int i = 0; i < 9; i++) begin
         chk("fwft_drain_dout", 32'(bus.dout), 32'(16'h0100 + i));
         bus.rd_en = 1'b1;
         tick();
      end
      idle();
      chk("fwft_drained", 32'(bus.empty), 1);
`else
      // Basic write then read.
      bus.wr_en = 1'b1;
      bus.din = 16'h0011; tick();
      bus.din = 16'h0022; tick();
      bus.din = 16'h0033; tick();
      idle();
      chk("wr3_count", 32'(bus.count), 3);
      chk("wr3_empty", 32'(bus.empty), 0);
      bus.rd_en = 1'b1;
      tick();
      chk("rd1_dout", 32'(bus.dout), 32'h11);
      chk("rd1_valid", 32'(bus.dout_valid), 1);
      chk("rd1_count", 32'(bus.count), 2);
      tick();
      chk("rd2_dout", 32'(bus.dout), 32'h22);
      chk("rd2_valid", 32'(bus.dout_valid), 1);
      tick();
      chk("rd3_dout", 32'(bus.dout), 32'h33);
      chk("rd3_count", 32'(bus.count), 0);
      chk("rd3_empty", 32'(bus.empty), 1);
      idle();
      tick();
      chk("hold_valid", 32'(bus.dout_valid), 0);
      chk("hold_dout", 32'(bus.dout), 32'h33);

      // Underflow and err_clr precedence.
      bus.rd_en = 1'b1;
      tick();
      idle();
      chk("uf_set", 32'(bus.underflow), 1);
      chk("uf_dout", 32'(bus.dout), 32'h33);
      chk("uf_count", 32'(bus.count), 0);
      bus.err_clr = 1'b1;
      tick();
      chk("uf_clr", 32'(bus.underflow), 0);
      bus.rd_en = 1'b1;
      tick();
      idle();
      chk("uf_clr_vs_set", 32'(bus.underflow), 1);
      bus.err_clr = 1'b1;
      tick();
      idle();

      // Fill with threshold sweep, then overflow with simultaneous read.
      chk("sweep_ae0", 32'(bus.almost_empty), 1);
      for (int i = 0; i < 8; i++) begin
         bus.wr_en = 1'b1;
         bus.din   = 16'(16'h0040 + i);
         tick();
         chk("fill_count", 32'(bus.count), 32'(i + 1));
         chk("fill_ae", 32'(bus.almost_empty), 32'((i + 1) <= 1));
         chk("fill_af", 32'(bus.almost_full), 32'((i + 1) >= 6));
         chk("fill_full", 32'(bus.full), 32'((i + 1) == 8));
      end
      bus.wr_en = 1'b1;
      bus.rd_en = 1'b1;
      bus.din   = 16'h00FF;
      tick();
      idle();
      chk("ovf_flag", 32'(bus.overflow), 1);
      chk("ovf_count", 32'(bus.count), 7);
      chk("ovf_dout", 32'(bus.dout), 32'h40);
      chk("ovf_full", 32'(bus.full), 0);
      for (int i = 0; i < 7; i++) begin
         bus.rd_en = 1'b1;
         tick();
         chk("drain_dout", 32'(bus.dout), 32'(16'h0041 + i));
         chk("drain_count", 32'(bus.count), 32'(6 - i));
         chk("drain_ae", 32'(bus.almost_empty), 32'((6 - i) <= 1));
         chk("drain_af", 32'(bus.almost_full), 32'((6 - i) >= 6));
      end
      idle();
      bus.err_clr = 1'b1;
      tick();
      idle();
      chk("ovf_clr", 32'(bus.overflow), 0);

      // Random streaming against a queue scoreboard.
      begin
         logic [W-1:0] q[$];
         logic [W-1:0] exp_word;
         int sent = 0;
         int recv = 0;
         int cyc  = 0;
         int mcnt = 0;
         int cnt_err = 0;
         while (recv < 1000 && cyc < 20000) begin
            logic wr;
            logic rd;
            logic wr_ok;
            logic rd_ok;
            wr = (sent < 1000) && ($urandom_range(99) < 55);
            rd = ($urandom_range(99) < 50);
            wr_ok = wr && (mcnt < 8);
            rd_ok = rd && (mcnt > 0);
            bus.wr_en = wr;
            bus.rd_en = rd;
            bus.din   = W'(sent * 7 + 3);
            exp_word  = '0;
            if (rd_ok) exp_word = q.pop_front();
            if (wr_ok) begin
               q.push_back(W'(sent * 7 + 3));
               sent++;
            end
            mcnt = mcnt + (wr_ok ? 1 : 0) - (rd_ok ? 1 : 0);
            tick();
            if (rd_ok) begin
               chk("stream_dout", 32'(bus.dout), 32'(exp_word));
               recv++;
            end
            if (32'(bus.count) != 32'(mcnt)) cnt_err++;
            cyc++;
         end
         idle();
         chk("stream_recv", 32'(recv), 1000);
         chk("stream_count_errs", 32'(cnt_err), 0);
      end

      // Reset in the middle of traffic.
      for (int i = 0; i < 5; i++) begin
         bus.wr_en = 1'b1;
         bus.din   = 16'(16'h0200 + i);
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle();
      chk("midrst_count", 32'(bus.count), 0);
      chk("midrst_empty", 32'(bus.empty), 1);
      chk("midrst_valid", 32'(bus.dout_valid), 0);
      bus.rd_en = 1'b1;
      tick();
      idle();
      chk("midrst_no_drain", 32'(bus.dout_valid), 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

`default_nettype wire
